// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, one step per clock, start/done handshake.
// Operands are extended to WIDTH+1 bits so one datapath covers signed and unsigned.
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH:0]   a;
    logic [WIDTH:0]   q;
    logic [WIDTH:0]   m;
    logic             q_1;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   x_ext;
    logic [WIDTH:0]   y_ext;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   a_nxt;
    logic [WIDTH:0]   q_nxt;
    logic [2*WIDTH+1:0] shifted;

    assign x_ext   = {signed_mode & x[WIDTH-1], x};
    assign y_ext   = {signed_mode & y[WIDTH-1], y};
    assign shifted = {a_nxt, q_nxt};

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sum = a;
        case ({q[0], q_1})
            2'b01:   sum = a + m;
            2'b10:   sum = a - m;
            default: sum = a;
        endcase
        a_nxt = {sum[WIDTH], sum[WIDTH:1]};
        q_nxt = {sum[0], q[WIDTH:1]};
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a       <= '0;
            q       <= '0;
            m       <= '0;
            q_1     <= 1'b0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a     <= '0;
                        q     <= x_ext;
                        m     <= y_ext;
                        q_1   <= 1'b0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a     <= a_nxt;
                    q     <= q_nxt;
                    q_1   <= q[0];
                    count <= count + CW'(1);
                    // The step taken with count == WIDTH is the last of WIDTH+1.
                    if (count == LAST) begin
                        product <= shifted[2*WIDTH-1:0];
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq at WIDTH=8 and WIDTH=4.
// Expected products come from a behavioural multiply pushed at start time.
module tb_booth_mult_seq;

    logic        clk;
    logic        rst_n;

    logic        start8, sm8, busy8, done8;
    logic [7:0]  x8, y8;
    logic [15:0] prod8;

    logic        start4, sm4, busy4, done4;
    logic [3:0]  x4, y4;
    logic [7:0]  prod4;

    int n_cmp = 0;
    int n_err = 0;
    int dcnt8 = 0;
    int dcnt4 = 0;

    logic [15:0] q8[$];
    logic [7:0]  q4[$];

    booth_mult_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
        .x(x8), .y(y8), .busy(busy8), .done(done8), .product(prod8)
    );

    booth_mult_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(sm4),
        .x(x4), .y(y4), .busy(busy4), .done(done4), .product(prod4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model8(input logic sm, input logic [7:0] a, input logic [7:0] b);
        logic signed [31:0] r;
        if (sm) r = $signed({{24{a[7]}}, a}) * $signed({{24{b[7]}}, b});
        else    r = $signed({24'b0, a}) * $signed({24'b0, b});
        return r[15:0];
    endfunction

    function automatic logic [7:0] model4(input logic sm, input logic [3:0] a, input logic [3:0] b);
        logic signed [31:0] r;
        if (sm) r = $signed({{28{a[3]}}, a}) * $signed({{28{b[3]}}, b});
        else    r = $signed({28'b0, a}) * $signed({28'b0, b});
        return r[7:0];
    endfunction

    // Scoreboard: compare against the oldest expected result on each done pulse.
    always @(negedge clk) begin
        if (done8) begin
            dcnt8++;
            if (q8.size() == 0) check("done8_unexpected", q8.size(), 1);
            else check("prod8", {16'b0, prod8}, {16'b0, q8.pop_front()});
        end
        if (done4) begin
            dcnt4++;
            if (q4.size() == 0) check("done4_unexpected", q4.size(), 1);
            else check("prod4", {24'b0, prod4}, {24'b0, q4.pop_front()});
        end
    end

    // Returns just after the edge that samples start.
    task automatic start_op8(input logic sm, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        start8 = 1'b1; sm8 = sm; x8 = a; y8 = b;
        q8.push_back(model8(sm, a, b));
        @(posedge clk); #1;
        start8 = 1'b0;
    endtask

    task automatic start_op4(input logic sm, input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        start4 = 1'b1; sm4 = sm; x4 = a; y4 = b;
        q4.push_back(model4(sm, a, b));
        @(posedge clk); #1;
        start4 = 1'b0;
    endtask

    task automatic wait_idle8();
        int n = 0;
        while ((busy8 || q8.size() != 0) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle8_in_budget", {31'b0, busy8}, 0);
        check("queue8_drained", q8.size(), 0);
    endtask

    task automatic wait_idle4();
        int n = 0;
        while ((busy4 || q4.size() != 0) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle4_in_budget", {31'b0, busy4}, 0);
        check("queue4_drained", q4.size(), 0);
    endtask

    task automatic wait_done_edge8();
        int n = 0;
        while (!done8 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("done8_in_budget", {31'b0, done8}, 1);
    endtask

    initial begin
        int d0;
        rst_n = 1'b0;
        start8 = 1'b0; sm8 = 1'b0; x8 = '0; y8 = '0;
        start4 = 1'b0; sm4 = 1'b0; x4 = '0; y4 = '0;
        #12;
        check("rst_busy8", {31'b0, busy8}, 0);
        check("rst_done8", {31'b0, done8}, 0);
        check("rst_prod8", {16'b0, prod8}, 0);
        check("rst_prod4", {24'b0, prod4}, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Unsigned 255*255 with cycle-exact latency.
        start_op8(1'b0, 8'd255, 8'd255);
        check("lat_busy_e0", {31'b0, busy8}, 1);
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); #1;
            if (i < 9) begin
                check("lat_busy", {31'b0, busy8}, 1);
                check("lat_nodone", {31'b0, done8}, 0);
            end else begin
                check("lat_done", {31'b0, done8}, 1);
                check("lat_busy_low", {31'b0, busy8}, 0);
                check("lat_prod", {16'b0, prod8}, 32'h0000FE01);
            end
        end
        @(posedge clk); #1;
        check("done_one_cycle", {31'b0, done8}, 0);
        wait_idle8();

        // Signed corners.
        start_op8(1'b1, 8'hFD, 8'h05); wait_idle8();
        start_op8(1'b1, 8'h80, 8'h80); wait_idle8();
        start_op8(1'b1, 8'h00, 8'h7F); wait_idle8();
        start_op8(1'b1, 8'h01, 8'h80); wait_idle8();
        start_op8(1'b1, 8'h7F, 8'h80); wait_idle8();
        start_op8(1'b0, 8'h80, 8'hFF); wait_idle8();

        // start during RUN is ignored; start in the done cycle is accepted.
        d0 = dcnt8;
        start_op8(1'b0, 8'd7, 8'd9);
        repeat (3) @(posedge clk);
        @(negedge clk); start8 = 1'b1; x8 = 8'd3; y8 = 8'd5;
        repeat (2) @(posedge clk);
        #1; start8 = 1'b0;
        wait_done_edge8();
        check("inflight_prod", {16'b0, prod8}, 32'd63);
        start8 = 1'b1; sm8 = 1'b0; x8 = 8'd3; y8 = 8'd5;
        q8.push_back(model8(1'b0, 8'd3, 8'd5));
        @(posedge clk); #1;
        start8 = 1'b0;
        check("b2b_accepted", {31'b0, busy8}, 1);
        repeat (3) @(posedge clk);
        #1;
        check("prod_held", {16'b0, prod8}, 32'd63);
        wait_idle8();
        check("b2b_done_count", dcnt8 - d0, 2);

        // Asynchronous reset mid-RUN aborts with no done.
        start_op8(1'b1, 8'h55, 8'hC3);
        repeat (4) @(posedge clk);
        @(negedge clk);
        d0 = dcnt8;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy8}, 0);
        check("abort_done", {31'b0, done8}, 0);
        check("abort_prod", {16'b0, prod8}, 0);
        q8.delete();
        @(negedge clk); rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("abort_no_done", dcnt8 - d0, 0);
        check("abort_idle", {31'b0, busy8}, 0);
        start_op8(1'b0, 8'd12, 8'd11); wait_idle8();

        // WIDTH=4 instance, with latency.
        start_op4(1'b0, 4'b0011, 4'b0101);
        repeat (4) @(posedge clk);
        #1;
        check("w4_busy_before", {31'b0, busy4}, 1);
        @(posedge clk); #1;
        check("w4_done_lat", {31'b0, done4}, 1);
        check("w4_prod_lat", {24'b0, prod4}, 32'h0F);
        wait_idle4();
        start_op4(1'b1, 4'hF, 4'h5); wait_idle4();
        start_op4(1'b1, 4'h8, 4'h8); wait_idle4();
        start_op4(1'b0, 4'hF, 4'hF); wait_idle4();

        // Random operands, both modes.
        for (int i = 0; i < 12; i++) begin
            start_op8(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            wait_idle8();
            start_op4(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom));
            wait_idle4();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
